mux_deserializer: RTL and testbench

MUX_DESERIALIZER -- requirements
Module: mux_deserializer

---
 rtl/guia07_pkg.sv | 13 +
 rtl/shift_reg_n.sv | 44 ++++
 rtl/mux_deserializer.sv | 133 +++++++++++++
 tb/tb_mux_deserializer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/guia07_pkg.sv
// Shared types and constants for the serial-to-parallel collector.
// Optional out_parity port is enabled by MUX_DESERIALIZER_PARITY_EN.
package guia07_pkg;

  typedef enum logic {
    SHIFT_IDLE = 1'b0,
    SHIFT      = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_MSB_FIRST = 1;

endpackage

// File: rtl/shift_reg_n.sv
// WIDTH-bit serial-in shift register with enable and async clear.
// The next value is exposed so the owner can capture a full word.
module shift_reg_n #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] shifted;

  // First bit drifts toward the MSB or the LSB end.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign shifted = {sr_q[WIDTH-2:0], din};
    end else begin : g_lsb
      assign shifted = {din, sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    sr_d = sr_q;
    if (en) begin
      sr_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign word = shifted;

endmodule

// File: rtl/mux_deserializer.sv
// Collects serial bits into WIDTH-bit words with a one-word output hold.
// Define MUX_DESERIALIZER_PARITY_EN to add the out_parity port.
module mux_deserializer
  import guia07_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = DEFAULT_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
`ifdef MUX_DESERIALIZER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] sr_word;
  logic             complete;
  logic             accept;

  shift_reg_n #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (in_valid),
    .din   (in_bit),
    .word  (sr_word)
  );

  assign complete = in_valid && (cnt_q == LAST);
  assign accept   = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_valid) begin
      unique case (state_q)
        SHIFT_IDLE: begin
          state_d = SHIFT;
          cnt_d   = CW'(1);
        end
        SHIFT: begin
          if (complete) begin
            state_d = SHIFT_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = SHIFT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Hold slot: a finished word is dropped only if the slot stays full.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (complete && (!valid_q || out_ready)) begin
      word_d  = sr_word;
      valid_d = 1'b1;
    end else if (complete) begin
      ovr_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SHIFT_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_word  = word_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;

`ifdef MUX_DESERIALIZER_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = ^word_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign out_parity = par_q;
`endif

endmodule

// File: tb/tb_mux_deserializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share stimulus.
// Define MUX_DESERIALIZER_PARITY_EN to also check out_parity.
module tb_mux_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] ow_m, ow_l;
  logic       ov_m, ov_l;
  logic       bz_m, bz_l;
  logic       or_m, or_l;
`ifdef MUX_DESERIALIZER_PARITY_EN
  logic       p_m, p_l;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  always #5 clk = ~clk;

  mux_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .out_word  (ow_m),
    .out_valid (ov_m),
    .out_ready (out_ready),
    .busy      (bz_m),
    .overrun   (or_m)
`ifdef MUX_DESERIALIZER_PARITY_EN
    ,
    .out_parity(p_m)
`endif
  );

  mux_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .out_word  (ow_l),
    .out_valid (ov_l),
    .out_ready (out_ready),
    .busy      (bz_l),
    .overrun   (or_l)
`ifdef MUX_DESERIALIZER_PARITY_EN
    ,
    .out_parity(p_l)
`endif
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    in_bit   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_both(input string nm,
                          input logic vm,
                          input logic vl,
                          input logic exp);
    chk({nm, "_msb"}, 32'(vm), 32'(exp));
    chk({nm, "_lsb"}, 32'(vl), 32'(exp));
  endtask

  initial begin
    logic [7:0] t1;
    logic [7:0] e;
    t1 = 8'hB2;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && ov_m && out_ready) begin
          if (q_m.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL msb_unexpected: got %0h expected none",
                     ow_m);
          end else begin
            e = q_m.pop_front();
            chk("msb_word", 32'(ow_m), 32'(e));
          end
        end
        if (rst_n && ov_l && out_ready) begin
          if (q_l.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL lsb_unexpected: got %0h expected none",
                     ow_l);
          end else begin
            e = q_l.pop_front();
            chk("lsb_word", 32'(ow_l), 32'(e));
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word", 32'(ow_m), 32'h0);
    chk_both("rst_valid", ov_m, ov_l, 1'b0);
    chk_both("rst_busy", bz_m, bz_l, 1'b0);
    chk_both("rst_ovr", or_m, or_l, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic word, both bit orders
    out_ready = 1'b1;
    q_m.push_back(8'hB2);
    q_l.push_back(8'h4D);
    for (int i = 7; i >= 1; i--) begin
      send_bit(t1[i]);
      chk("t1_busy", 32'(bz_m), 32'h1);
    end
    send_bit(t1[0]);
    chk_both("t1_busy_end", bz_m, bz_l, 1'b0);
    chk_both("t1_valid", ov_m, ov_l, 1'b1);
    idle(1);
    chk_both("t1_valid_clr", ov_m, ov_l, 1'b0);

    // Gap in the middle of a word
    q_m.push_back(8'hFF);
    q_l.push_back(8'hFF);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("gap_busy", 32'(bz_m), 32'h1);
      chk("gap_valid", 32'(ov_m), 32'h0);
    end
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    chk("gap_valid7", 32'(ov_m), 32'h0);
    send_bit(1'b1);
    chk_both("gap_valid8", ov_m, ov_l, 1'b1);
    idle(1);

    // Overrun while the slot is full
    out_ready = 1'b0;
    q_m.push_back(8'hA5);
    q_l.push_back(8'hA5);
    send_byte(8'hA5);
    chk("ovr_first_valid", 32'(ov_m), 32'h1);
    send_byte(8'h3C);
    chk_both("ovr_pulse", or_m, or_l, 1'b1);
    chk("ovr_word_kept", 32'(ow_m), 32'hA5);
    idle(1);
    chk_both("ovr_pulse_end", or_m, or_l, 1'b0);
    chk("ovr_valid_held", 32'(ov_m), 32'h1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_both("ovr_valid_clr", ov_m, ov_l, 1'b0);

    // Accept and complete on the same edge
    out_ready = 1'b0;
    q_m.push_back(8'hA5);
    q_l.push_back(8'hA5);
    q_m.push_back(8'h3C);
    q_l.push_back(8'h3C);
    send_byte(8'hA5);
    t1 = 8'h3C;
    for (int i = 7; i >= 1; i--) send_bit(t1[i]);
    out_ready = 1'b1;
    send_bit(t1[0]);
    chk_both("same_valid", ov_m, ov_l, 1'b1);
    chk("same_word", 32'(ow_m), 32'h3C);
    chk_both("same_ovr", or_m, or_l, 1'b0);
    idle(1);
    chk_both("same_valid_clr", ov_m, ov_l, 1'b0);

    // Async reset mid-word
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_word", 32'(ow_m), 32'h0);
    chk_both("mid_rst_busy", bz_m, bz_l, 1'b0);
    chk_both("mid_rst_valid", ov_m, ov_l, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q_m.push_back(8'hFF);
    q_l.push_back(8'hFF);
    send_byte(8'hFF);
    chk("post_rst_word", 32'(ow_m), 32'hFF);
`ifdef MUX_DESERIALIZER_PARITY_EN
    chk("par_ff", 32'(p_m), 32'h0);
`endif
    idle(1);
    q_m.push_back(8'h07);
    q_l.push_back(8'hE0);
    send_byte(8'h07);
    chk("w07_word", 32'(ow_m), 32'h07);
    chk("w07_word_lsb", 32'(ow_l), 32'hE0);
`ifdef MUX_DESERIALIZER_PARITY_EN
    chk("par_07", 32'(p_m), 32'h1);
    chk("par_e0", 32'(p_l), 32'h1);
`endif
    idle(3);

    chk("msb_q_empty", 32'(q_m.size()), 32'h0);
    chk("lsb_q_empty", 32'(q_l.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
